// File: rtl/lsu_mem_access.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_access
// Description : MEM-stage load/store sequencer. Turns a MEM-stage access into
//               a req/gnt/rvalid data-memory transaction and stalls the
//               pipeline until it completes.
//
//               Stores: write data is replicated across byte lanes and a byte
//               strobe is generated. Loads: the raw word, addr[1:0] and the
//               load type are returned, registered, to the load-extension
//               stage.
//
//               LoadCon : LW=0 LB=1 LH=2 LHU=3 LBU=4
//               StoreCon: SW=0 SB=1 SH=2
//
// Parameters  : ALLOW_MISALIGN  1: unaligned half/word issued as aligned word
//                               0: unaligned half/word rejected (misalign_err)
//               TIMEOUT         max cycles spent in REQ+WAIT (1..255)
//
// Ports       : clk, rst_n                 clock / async active-low reset
//               mem_valid, mem_is_load,
//               mem_is_store, mem_addr,
//               mem_wdata, mem_size        MEM-stage access
//               stall                      hold pipeline (combinational)
//               misalign_err, bus_err      1-cycle error pulses
//               load_valid, load_rdata,
//               load_addr_lo, load_con     load result to extension stage
//               dm_req, dm_we, dm_addr,
//               dm_wdata, dm_wstrb         data-memory request
//               dm_gnt, dm_rvalid,
//               dm_rdata                   data-memory response
//
// Revision    : 1.0  initial release
// ============================================================================
module lsu_mem_access #(
    parameter bit          ALLOW_MISALIGN = 1'b0,
    parameter int unsigned TIMEOUT        = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    // MEM-stage access
    input  logic        mem_valid,
    input  logic        mem_is_load,
    input  logic        mem_is_store,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_size,
    // Pipeline control and status
    output logic        stall,
    output logic        misalign_err,
    output logic        bus_err,
    // Load result
    output logic        load_valid,
    output logic [31:0] load_rdata,
    output logic [1:0]  load_addr_lo,
    output logic [2:0]  load_con,
    // Data-memory port
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_wstrb,
    input  logic        dm_gnt,
    input  logic        dm_rvalid,
    input  logic [31:0] dm_rdata
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    localparam logic [2:0] c_lw  = 3'd0;
    localparam logic [2:0] c_lh  = 3'd2;
    localparam logic [2:0] c_lhu = 3'd3;

    localparam logic [2:0] c_sw  = 3'd0;
    localparam logic [2:0] c_sb  = 3'd1;
    localparam logic [2:0] c_sh  = 3'd2;

    // Counter value seen in the last permitted REQ/WAIT cycle.
    localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic        r_txn_load;
    logic        r_dm_req;
    logic        r_dm_we;
    logic [31:0] r_dm_addr;
    logic [31:0] r_dm_wdata;
    logic [3:0]  r_dm_wstrb;
    logic        r_load_valid;
    logic [31:0] r_load_rdata;
    logic [1:0]  r_load_addr_lo;
    logic [2:0]  r_load_con;
    logic        r_misalign_err;
    logic        r_bus_err;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic        w_access;
    logic        w_misalign;
    logic        w_reject;
    logic [31:0] w_st_wdata;
    logic [3:0]  w_st_wstrb;
    logic [1:0]  w_state_nxt;
    logic        w_timeout;
    logic        w_issue;

    assign w_access = mem_valid & (mem_is_load | mem_is_store);

    // Alignment check: words need addr[1:0]==0, halves need addr[0]==0.
    always_comb begin
        w_misalign = 1'b0;
        if (mem_is_load) begin
            unique case (mem_size)
                c_lw:        w_misalign = |mem_addr[1:0];
                c_lh, c_lhu: w_misalign = mem_addr[0];
                default:     w_misalign = 1'b0;
            endcase
        end else if (mem_is_store) begin
            unique case (mem_size)
                c_sw:    w_misalign = |mem_addr[1:0];
                c_sh:    w_misalign = mem_addr[0];
                default: w_misalign = 1'b0;
            endcase
        end
    end

    assign w_reject = w_misalign & ~ALLOW_MISALIGN;
    assign w_issue  = (r_state == c_st_idle) & w_access & ~w_reject;

    // Store lane replication and byte strobe. An unknown StoreCon still goes
    // out on the bus, but with no byte lanes enabled.
    always_comb begin
        w_st_wdata = mem_wdata;
        w_st_wstrb = 4'b0000;
        unique case (mem_size)
            c_sb: begin
                w_st_wdata = {4{mem_wdata[7:0]}};
                w_st_wstrb = 4'b0001 << mem_addr[1:0];
            end
            c_sh: begin
                w_st_wdata = {2{mem_wdata[15:0]}};
                w_st_wstrb = mem_addr[1] ? 4'b1100 : 4'b0011;
            end
            c_sw: begin
                w_st_wdata = mem_wdata;
                w_st_wstrb = 4'b1111;
            end
            default: begin
                w_st_wdata = mem_wdata;
                w_st_wstrb = 4'b0000;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // A completing gnt/rvalid wins over the timeout in the same cycle.
    // DONE always returns to IDLE so the instruction still sitting in MEM
    // during DONE is never issued a second time.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        unique case (r_state)
            c_st_idle: begin
                if (w_access) begin
                    w_state_nxt = w_reject ? c_st_done : c_st_req;
                end
            end
            c_st_req: begin
                if (dm_gnt) begin
                    w_state_nxt = r_dm_we ? c_st_done : c_st_wait;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = c_st_done;
                    w_timeout   = 1'b1;
                end
            end
            c_st_wait: begin
                if (dm_rvalid) begin
                    w_state_nxt = c_st_done;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = c_st_done;
                    w_timeout   = 1'b1;
                end
            end
            c_st_done: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    // Reset gating keeps the pipeline free while the sequencer is held in
    // reset, even if MEM still presents an access.
    assign stall = w_access & (r_state != c_st_done) & rst_n;

    // ------------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt          <= 8'd0;
            r_txn_load     <= 1'b0;
            r_dm_req       <= 1'b0;
            r_dm_we        <= 1'b0;
            r_dm_addr      <= 32'd0;
            r_dm_wdata     <= 32'd0;
            r_dm_wstrb     <= 4'd0;
            r_load_valid   <= 1'b0;
            r_load_rdata   <= 32'd0;
            r_load_addr_lo <= 2'd0;
            r_load_con     <= 3'd0;
            r_misalign_err <= 1'b0;
            r_bus_err      <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses landing in DONE.
            r_load_valid   <= 1'b0;
            r_misalign_err <= 1'b0;
            r_bus_err      <= 1'b0;

            if (r_state == c_st_idle) begin
                r_cnt <= 8'd0;
                if (w_access & w_reject) begin
                    r_misalign_err <= 1'b1;
                end
            end else if ((r_state == c_st_req) || (r_state == c_st_wait)) begin
                r_cnt <= r_cnt + 8'd1;
            end

            if (w_issue) begin
                r_dm_req   <= 1'b1;
                r_dm_we    <= mem_is_store;
                r_dm_addr  <= {mem_addr[31:2], 2'b00};
                r_dm_wdata <= mem_is_store ? w_st_wdata : 32'd0;
                r_dm_wstrb <= mem_is_store ? w_st_wstrb : 4'b0000;
                r_txn_load <= mem_is_load;
                if (mem_is_load) begin
                    r_load_addr_lo <= mem_addr[1:0];
                    r_load_con     <= mem_size;
                end
            end

            if ((r_state == c_st_req) && dm_gnt) begin
                r_dm_req <= 1'b0;
            end

            if ((r_state == c_st_wait) && dm_rvalid) begin
                r_load_rdata <= dm_rdata;
                r_load_valid <= 1'b1;
            end

            // On timeout a load still completes, with a zero word, so the
            // pipeline sees a well-defined writeback alongside bus_err.
            if (w_timeout) begin
                r_dm_req  <= 1'b0;
                r_bus_err <= 1'b1;
                if (r_txn_load) begin
                    r_load_rdata <= 32'd0;
                    r_load_valid <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output assignments
    // ------------------------------------------------------------------------
    assign dm_req       = r_dm_req;
    assign dm_we        = r_dm_we;
    assign dm_addr      = r_dm_addr;
    assign dm_wdata     = r_dm_wdata;
    assign dm_wstrb     = r_dm_wstrb;
    assign load_valid   = r_load_valid;
    assign load_rdata   = r_load_rdata;
    assign load_addr_lo = r_load_addr_lo;
    assign load_con     = r_load_con;
    assign misalign_err = r_misalign_err;
    assign bus_err      = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_access.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_lsu_mem_access
// Description : Directed self-checking bench for lsu_mem_access. One instance
//               rejects misaligned accesses, a second one allows them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_lsu_mem_access;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Instance a: ALLOW_MISALIGN=0, TIMEOUT=255
    logic        mem_valid, mem_is_load, mem_is_store;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_size;
    logic        stall, misalign_err, bus_err, load_valid;
    logic [31:0] load_rdata;
    logic [1:0]  load_addr_lo;
    logic [2:0]  load_con;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;

    // Instance b: ALLOW_MISALIGN=1
    logic        mv_b, ld_b, st_b;
    logic [31:0] addr_b, wdata_b;
    logic [2:0]  size_b;
    logic        stall_b, misalign_err_b, bus_err_b, load_valid_b;
    logic [31:0] load_rdata_b;
    logic [1:0]  load_addr_lo_b;
    logic [2:0]  load_con_b;
    logic        dm_req_b, dm_we_b;
    logic [31:0] dm_addr_b, dm_wdata_b;
    logic [3:0]  dm_wstrb_b;
    logic        gnt_b, rvalid_b;
    logic [31:0] rdata_b;

    lsu_mem_access #(.ALLOW_MISALIGN(1'b0), .TIMEOUT(255)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_is_load(mem_is_load), .mem_is_store(mem_is_store),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
        .stall(stall), .misalign_err(misalign_err), .bus_err(bus_err),
        .load_valid(load_valid), .load_rdata(load_rdata),
        .load_addr_lo(load_addr_lo), .load_con(load_con),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata)
    );

    lsu_mem_access #(.ALLOW_MISALIGN(1'b1), .TIMEOUT(255)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mv_b), .mem_is_load(ld_b), .mem_is_store(st_b),
        .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_size(size_b),
        .stall(stall_b), .misalign_err(misalign_err_b), .bus_err(bus_err_b),
        .load_valid(load_valid_b), .load_rdata(load_rdata_b),
        .load_addr_lo(load_addr_lo_b), .load_con(load_con_b),
        .dm_req(dm_req_b), .dm_we(dm_we_b), .dm_addr(dm_addr_b),
        .dm_wdata(dm_wdata_b), .dm_wstrb(dm_wstrb_b),
        .dm_gnt(gnt_b), .dm_rvalid(rvalid_b), .dm_rdata(rdata_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Free-running count of cycles with dm_req high on instance a.
    int req_cycles = 0;
    always @(negedge clk) if (dm_req) req_cycles++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic issue(input logic is_ld, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] sz);
        mem_valid    = 1'b1;
        mem_is_load  = is_ld;
        mem_is_store = ~is_ld;
        mem_addr     = a;
        mem_wdata    = d;
        mem_size     = sz;
    endtask

    task automatic drop();
        mem_valid    = 1'b0;
        mem_is_load  = 1'b0;
        mem_is_store = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int hi;
        logic seen;

        rst_n = 1'b0;
        drop();
        mem_addr = '0; mem_wdata = '0; mem_size = '0;
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
        mv_b = 1'b0; ld_b = 1'b0; st_b = 1'b0;
        addr_b = '0; wdata_b = '0; size_b = '0;
        gnt_b = 1'b0; rvalid_b = 1'b0; rdata_b = '0;

        // ---------------- reset state
        cyc(); cyc();
        check("rst_dm_req", dm_req, 0);
        check("rst_stall", stall, 0);
        check("rst_load_valid", load_valid, 0);
        check("rst_load_rdata", load_rdata, 0);
        check("rst_dm_wstrb", dm_wstrb, 0);
        check("rst_dm_addr", dm_addr, 0);
        rst_n = 1'b1;
        cyc();

        // ---------------- SB 0xA5 @0x1003, gnt after two waiting cycles
        s = req_cycles;
        issue(1'b0, 32'h0000_1003, 32'h0000_00A5, 3'd1); settle();
        check("sb_idle_stall", stall, 1);
        check("sb_idle_noreq", dm_req, 0);
        cyc();
        check("sb_req", dm_req, 1);
        check("sb_addr", dm_addr, 32'h0000_1000);
        check("sb_wdata", dm_wdata, 32'hA5A5_A5A5);
        check("sb_wstrb", dm_wstrb, 4'b1000);
        check("sb_we", dm_we, 1);
        check("sb_req_stall", stall, 1);
        cyc();
        check("sb_hold_addr", dm_addr, 32'h0000_1000);
        check("sb_hold_req", dm_req, 1);
        cyc();
        dm_gnt = 1'b1; settle();
        check("sb_gnt_stall", stall, 1);
        check("sb_gnt_req", dm_req, 1);
        cyc();
        dm_gnt = 1'b0; settle();
        check("sb_done_stall", stall, 0);
        check("sb_done_req", dm_req, 0);
        check("sb_done_lvalid", load_valid, 0);
        cyc();
        drop(); settle();
        check("sb_req_cycles", req_cycles - s, 3);

        // ---------------- LH @0x2002, rvalid three cycles after gnt
        s = req_cycles;
        issue(1'b1, 32'h0000_2002, 32'h0, 3'd2); settle();
        check("lh_idle_stall", stall, 1);
        cyc();
        check("lh_req", dm_req, 1);
        check("lh_we", dm_we, 0);
        check("lh_wstrb", dm_wstrb, 0);
        check("lh_addr", dm_addr, 32'h0000_2000);
        dm_gnt = 1'b1;
        cyc();
        dm_gnt = 1'b0; settle();
        check("lh_wait_req", dm_req, 0);
        check("lh_wait_stall", stall, 1);
        cyc();
        cyc();
        check("lh_wait_noval", load_valid, 0);
        dm_rvalid = 1'b1; dm_rdata = 32'h8001_7FFF; settle();
        check("lh_rv_stall", stall, 1);
        cyc();
        dm_rvalid = 1'b0; dm_rdata = 32'h0; settle();
        check("lh_lvalid", load_valid, 1);
        check("lh_rdata", load_rdata, 32'h8001_7FFF);
        check("lh_addr_lo", load_addr_lo, 2);
        check("lh_con", load_con, 2);
        check("lh_done_stall", stall, 0);
        cyc();
        drop(); settle();
        check("lh_lvalid_pulse", load_valid, 0);
        check("lh_addr_lo_held", load_addr_lo, 2);
        check("lh_req_cycles", req_cycles - s, 1);

        // ---------------- SW @0x3001 rejected (instance a)
        s = req_cycles;
        issue(1'b0, 32'h0000_3001, 32'h1122_3344, 3'd0); settle();
        check("ma_idle_stall", stall, 1);
        cyc();
        check("ma_err", misalign_err, 1);
        check("ma_done_stall", stall, 0);
        check("ma_noreq", dm_req, 0);
        cyc();
        drop(); settle();
        check("ma_err_pulse", misalign_err, 0);
        check("ma_req_cycles", req_cycles - s, 0);

        // ---------------- SW @0x3001 allowed (instance b)
        mv_b = 1'b1; st_b = 1'b1; addr_b = 32'h0000_3001;
        wdata_b = 32'h1122_3344; size_b = 3'd0; settle();
        check("mab_idle_stall", stall_b, 1);
        cyc();
        check("mab_req", dm_req_b, 1);
        check("mab_addr", dm_addr_b, 32'h0000_3000);
        check("mab_wstrb", dm_wstrb_b, 4'b1111);
        check("mab_wdata", dm_wdata_b, 32'h1122_3344);
        check("mab_noerr_req", misalign_err_b, 0);
        gnt_b = 1'b1;
        cyc();
        gnt_b = 1'b0; settle();
        check("mab_noerr_done", misalign_err_b, 0);
        check("mab_done_stall", stall_b, 0);
        cyc();
        mv_b = 1'b0; st_b = 1'b0;

        // ---------------- LW with gnt withheld -> timeout
        issue(1'b1, 32'h0000_4000, 32'h0, 3'd0);
        hi = 0;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            cyc();
            if (bus_err) begin
                seen = 1'b1;
                break;
            end
            if (dm_req) hi++;
        end
        check("to_bus_err", seen, 1);
        check("to_req_cycles", hi, 255);
        check("to_lvalid", load_valid, 1);
        check("to_rdata_zero", load_rdata, 0);
        check("to_done_stall", stall, 0);
        check("to_done_req", dm_req, 0);
        cyc();
        drop(); settle();
        check("to_err_pulse", bus_err, 0);
        // late response while idle must be ignored
        dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = 32'hFFFF_FFFF;
        cyc();
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0; settle();
        check("late_noreq", dm_req, 0);
        check("late_nolvalid", load_valid, 0);
        check("late_rdata", load_rdata, 0);
        // next instruction issues normally
        issue(1'b1, 32'h0000_4004, 32'h0, 3'd0);
        cyc();
        check("post_to_req", dm_req, 1);
        check("post_to_addr", dm_addr, 32'h0000_4004);
        dm_gnt = 1'b1;
        cyc();
        dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h1234_5678;
        cyc();
        dm_rvalid = 1'b0; dm_rdata = 32'h0; settle();
        check("post_to_lvalid", load_valid, 1);
        check("post_to_rdata", load_rdata, 32'h1234_5678);
        check("post_to_con", load_con, 0);
        cyc();
        drop();

        // ---------------- back-to-back SH @0x10 then LBU @0x13
        s = req_cycles;
        issue(1'b0, 32'h0000_0010, 32'h0000_BEEF, 3'd2);
        cyc();
        check("sh_wstrb", dm_wstrb, 4'b0011);
        check("sh_wdata", dm_wdata, 32'hBEEF_BEEF);
        check("sh_req", dm_req, 1);
        dm_gnt = 1'b1;
        cyc();
        dm_gnt = 1'b0; settle();
        check("sh_done_stall", stall, 0);
        cyc();
        issue(1'b1, 32'h0000_0013, 32'h0, 3'd4); settle();
        check("lbu_idle_stall", stall, 1);
        cyc();
        check("lbu_wstrb", dm_wstrb, 4'b0000);
        check("lbu_we", dm_we, 0);
        check("lbu_addr", dm_addr, 32'h0000_0010);
        dm_gnt = 1'b1;
        cyc();
        dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'hDEAD_BEEF;
        cyc();
        dm_rvalid = 1'b0; dm_rdata = 32'h0; settle();
        check("lbu_lvalid", load_valid, 1);
        check("lbu_rdata", load_rdata, 32'hDEAD_BEEF);
        check("lbu_addr_lo", load_addr_lo, 3);
        check("lbu_con", load_con, 4);
        cyc();
        drop();
        cyc();
        check("b2b_req_cycles", req_cycles - s, 2);

        // ---------------- async reset while in REQ
        issue(1'b1, 32'h0000_6000, 32'h0, 3'd0);
        cyc();
        check("rq_rst_req_before", dm_req, 1);
        #2 rst_n = 1'b0; settle();
        check("rq_rst_req", dm_req, 0);
        check("rq_rst_stall", stall, 0);
        drop();
        #3 rst_n = 1'b1;
        cyc();

        // ---------------- async reset while in WAIT
        issue(1'b1, 32'h0000_5000, 32'h0, 3'd0);
        cyc();
        dm_gnt = 1'b1;
        cyc();
        dm_gnt = 1'b0; settle();
        check("wt_stall_before", stall, 1);
        #2 rst_n = 1'b0; settle();
        check("wt_rst_req", dm_req, 0);
        check("wt_rst_stall", stall, 0);
        drop();
        #3 rst_n = 1'b1;
        cyc();
        issue(1'b1, 32'h0000_5008, 32'h0, 3'd0);
        cyc();
        check("wt_new_req", dm_req, 1);
        check("wt_new_addr", dm_addr, 32'h0000_5008);
        dm_gnt = 1'b1;
        cyc();
        dm_gnt = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'hCAFE_F00D;
        cyc();
        dm_rvalid = 1'b0; dm_rdata = 32'h0; settle();
        check("wt_new_lvalid", load_valid, 1);
        check("wt_new_rdata", load_rdata, 32'hCAFE_F00D);
        cyc();
        drop();
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
